// File: rtl/fetch_gshare_unit_pkg.sv
// Shared types for the fetch stage: FSM states, predictor modes, RV32I opcodes.
// No logic, so no latency.
// Immediate decode helpers are used by the prediction path.
package fetch_gshare_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    localparam int BP_STATIC = 0;
    localparam int BP_GSHARE = 1;

    typedef enum logic [6:0] {
        op_b_lui   = 7'b0110111,
        op_b_auipc = 7'b0010111,
        op_b_jal   = 7'b1101111,
        op_b_jalr  = 7'b1100111,
        op_b_br    = 7'b1100011,
        op_b_load  = 7'b0000011,
        op_b_store = 7'b0100011,
        op_b_imm   = 7'b0010011,
        op_b_reg   = 7'b0110011
    } rv32i_opcode_t;

    // Sign-extended B-type immediate.
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // Sign-extended J-type immediate.
    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_gshare_pht.sv
// Pattern history table of 2-bit saturating counters.
// Read is combinational; an update lands on the next clock edge.
// No backpressure: one update per cycle is always accepted.
module fetch_gshare_pht #(
    parameter int         PHT_ENTRIES = 1024,
    parameter logic [1:0] CTR_INIT    = 2'b10,
    localparam int        IW          = $clog2(PHT_ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] rd_idx,
    output logic [1:0]    rd_ctr,
    input  logic          upd_vld,
    input  logic [IW-1:0] upd_idx,
    input  logic          upd_taken
);

    logic [1:0] r_ctr [PHT_ENTRIES];

    assign rd_ctr = r_ctr[rd_idx];

    // Counter array: reset to the init value, saturating increment/decrement on update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                r_ctr[i] <= CTR_INIT;
            end
        end else if (upd_vld) begin
            if (upd_taken && r_ctr[upd_idx] != 2'b11) begin
                r_ctr[upd_idx] <= r_ctr[upd_idx] + 2'd1;
            end else if (!upd_taken && r_ctr[upd_idx] != 2'b00) begin
                r_ctr[upd_idx] <= r_ctr[upd_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/fetch_gshare_unit.sv
// In-order fetch with one outstanding I-cache request and gshare/BTFN direction prediction.
// Issue is combinational from state; a response is pushed in the cycle it arrives.
// A full fetch queue holds off issue only; a redirect drops exactly one in-flight response.
module fetch_gshare_unit
    import fetch_gshare_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h1eceb000,
    parameter int          PHT_ENTRIES = 1024,
    parameter int          GHR_W       = 8,
    parameter int          BP_MODE     = 1,
    parameter logic [1:0]  CTR_INIT    = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ufp_addr,
    output logic [3:0]  ufp_rmask,
    input  logic        ufp_resp,
    input  logic [31:0] ufp_rdata,
    input  logic        fq_full,
    output logic        fq_push,
    output logic [31:0] fq_inst,
    output logic [31:0] fq_pc,
    output logic [63:0] fq_order,
    output logic        fq_pred_taken,
    output logic [31:0] fq_pred_target,
    input  logic        branch_mispredict,
    input  logic [31:0] new_fetch_pc,
    input  logic [63:0] new_fetch_order,
    input  logic        br_update,
    input  logic        br_taken,
    input  logic [31:0] br_pc
);

    localparam int IW = $clog2(PHT_ENTRIES);

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [31:0]   r_pc;          // PC of the outstanding (or next) request
    logic [63:0]   r_order;       // order the next pushed instruction gets
    logic [GHR_W-1:0] r_ghr;

    logic [IW-1:0] w_ghr_ext;
    logic [IW-1:0] w_lookup_idx;
    logic [IW-1:0] w_update_idx;
    logic [1:0]    w_pht_ctr;
    logic          w_pred_taken;
    logic [31:0]   w_pred_target;
    logic          w_slot_free;
    logic          w_issue;
    logic          w_push;
    logic [31:0]   w_issue_addr;
    logic          w_unused;

    assign w_ghr_ext    = IW'(r_ghr);
    assign w_lookup_idx = r_pc[2 +: IW] ^ w_ghr_ext;
    assign w_update_idx = br_pc[2 +: IW] ^ w_ghr_ext;
    assign w_unused     = ^{br_pc, w_pht_ctr};

    fetch_gshare_pht #(
        .PHT_ENTRIES (PHT_ENTRIES),
        .CTR_INIT    (CTR_INIT)
    ) u_pht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (w_lookup_idx),
        .rd_ctr    (w_pht_ctr),
        .upd_vld   (br_update),
        .upd_idx   (w_update_idx),
        .upd_taken (br_taken)
    );

    // A new request may go out when nothing is outstanding or the outstanding one returns now.
    assign w_slot_free  = (r_state == IDLE) || ufp_resp;
    assign w_issue      = w_slot_free && !fq_full && !rst;
    assign w_push       = (r_state == WAIT) && ufp_resp && !branch_mispredict && !rst;
    assign w_issue_addr = branch_mispredict  ? new_fetch_pc :
                          (r_state == WAIT)  ? w_pred_target : r_pc;

    // Direction/target prediction decoded straight off the returning instruction word.
    always_comb begin
        w_pred_taken  = 1'b0;
        w_pred_target = r_pc + 32'd4;
        if (ufp_rdata[6:0] == op_b_br) begin
            if (BP_MODE == BP_GSHARE) begin
                w_pred_taken = w_pht_ctr[1];
            end else begin
                w_pred_taken = ufp_rdata[31];
            end
            if (w_pred_taken) begin
                w_pred_target = r_pc + imm_b(ufp_rdata);
            end
        end else if (ufp_rdata[6:0] == op_b_jal) begin
            w_pred_taken  = 1'b1;
            w_pred_target = r_pc + imm_j(ufp_rdata);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a free slot either reissues or parks in IDLE; a redirect with a
    // request still in flight must swallow its response first.
    always_comb begin
        w_state_next = r_state;
        if (w_slot_free) begin
            w_state_next = fq_full ? IDLE : WAIT;
        end else if (branch_mispredict) begin
            w_state_next = SQUASH;
        end
    end

    // Outputs: everything is forced to zero outside an issue/push cycle.
    always_comb begin
        ufp_rmask      = w_issue ? 4'b1111 : 4'b0000;
        ufp_addr       = w_issue ? w_issue_addr : 32'd0;
        fq_push        = w_push;
        fq_inst        = w_push ? ufp_rdata : 32'd0;
        fq_pc          = w_push ? r_pc : 32'd0;
        fq_order       = w_push ? r_order : 64'd0;
        fq_pred_taken  = w_push ? w_pred_taken : 1'b0;
        fq_pred_target = w_push ? w_pred_target : 32'd0;
    end

    // PC/order follow redirects first, then pushes; GHR shifts on every resolved branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_order <= 64'd0;
            r_ghr   <= '0;
        end else begin
            if (branch_mispredict) begin
                r_pc    <= new_fetch_pc;
                r_order <= new_fetch_order + 64'd1;
            end else if (w_push) begin
                r_pc    <= w_pred_target;
                r_order <= r_order + 64'd1;
            end
            if (br_update) begin
                r_ghr <= GHR_W'({r_ghr, br_taken});
            end
        end
    end

endmodule
